// File: rtl/lvt_mem_scheduler.sv
// lvt_mem_scheduler: front-end arbiter and sequencer for a 2-write/1-read LVT
// multiported memory. It shares the memory between NREQ requesters, grants up
// to two writes and one read per cycle while avoiding same-address hazards,
// tags read responses with the requester ID, and clears the whole memory with
// a write sweep after every reset.
module lvt_mem_scheduler #(
   parameter int NREQ    = 4,
   parameter int ADDR_W  = 7,
   parameter int DATA_W  = 32,
   parameter int RD_LAT  = 1,
   parameter int INIT_EN = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ-1:0]           req_we,
   input  logic [NREQ*ADDR_W-1:0]    req_addr,
   input  logic [NREQ*DATA_W-1:0]    req_wdata,
   output logic [NREQ-1:0]           req_ready,
   output logic                      rsp_valid,
   output logic [$clog2(NREQ)-1:0]   rsp_id,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      wr0_en,
   output logic [ADDR_W-1:0]         wr0_addr,
   output logic [DATA_W-1:0]         wr0_data,
   output logic                      wr1_en,
   output logic [ADDR_W-1:0]         wr1_addr,
   output logic [DATA_W-1:0]         wr1_data,
   output logic                      rd0_en,
   output logic [ADDR_W-1:0]         rd0_addr,
   input  logic [DATA_W-1:0]         rd0_data,
   output logic                      init_busy
);

   localparam int ID_W = $clog2(NREQ);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   init_cnt;
   logic [ID_W-1:0]     wptr;
   logic [ID_W-1:0]     rptr;
   logic [ID_W-1:0]     rd_id;

   logic [ADDR_W-1:0]   addr_arr  [NREQ];
   logic [DATA_W-1:0]   wdata_arr [NREQ];

   logic                arb_en;
   logic                w0_found;
   logic                w1_found;
   logic                r_found;
   logic [ID_W-1:0]     w0_idx;
   logic [ID_W-1:0]     w1_idx;
   logic [ID_W-1:0]     r_idx;
   logic [ADDR_W-1:0]   w0_addr;
   logic [ADDR_W-1:0]   w1_addr;
   logic [NREQ-1:0]     grant;

   logic [RD_LAT-1:0]   pipe_valid;
   logic [ID_W-1:0]     pipe_id [RD_LAT];

   // Round-robin successor of a requester index
   function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] i);
      return ID_W'((int'(i) + 1) % NREQ);
   endfunction

   // Grants are only issued once the clear sweep has fully drained
   assign arb_en    = (state == S_RUN) && !init_busy;
   assign req_ready = grant;

   // Unpack the flat request buses into per-requester arrays
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
         wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
      end
   end

   // Pick W0/W1 round-robin from wptr, then a non-conflicting read from rptr
   always_comb begin
      logic [ID_W-1:0] idx;
      idx      = '0;
      w0_found = 1'b0;
      w1_found = 1'b0;
      r_found  = 1'b0;
      w0_idx   = '0;
      w1_idx   = '0;
      r_idx    = '0;
      w0_addr  = '0;
      w1_addr  = '0;
      grant    = '0;
      if (arb_en) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = ID_W'((int'(wptr) + k) % NREQ);
            if (req_valid[idx] && req_we[idx]) begin
               if (!w0_found) begin
                  w0_found = 1'b1;
                  w0_idx   = idx;
                  w0_addr  = addr_arr[idx];
               end else if (!w1_found && (addr_arr[idx] != w0_addr)) begin
                  w1_found = 1'b1;
                  w1_idx   = idx;
                  w1_addr  = addr_arr[idx];
               end
            end
         end
         for (int k = 0; k < NREQ; k++) begin
            idx = ID_W'((int'(rptr) + k) % NREQ);
            if (!r_found && req_valid[idx] && !req_we[idx]
                && !(w0_found && (addr_arr[idx] == w0_addr))
                && !(w1_found && (addr_arr[idx] == w1_addr))) begin
               r_found = 1'b1;
               r_idx   = idx;
            end
         end
         if (w0_found) grant[w0_idx] = 1'b1;
         if (w1_found) grant[w1_idx] = 1'b1;
         if (r_found)  grant[r_idx]  = 1'b1;
      end
   end

   // Control FSM: clear sweep after reset, then register granted slots onto the memory ports
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= (INIT_EN != 0) ? S_INIT : S_RUN;
         init_busy <= 1'b0;
         init_cnt  <= '0;
         wptr      <= '0;
         rptr      <= '0;
         rd_id     <= '0;
         wr0_en    <= 1'b0;
         wr0_addr  <= '0;
         wr0_data  <= '0;
         wr1_en    <= 1'b0;
         wr1_addr  <= '0;
         wr1_data  <= '0;
         rd0_en    <= 1'b0;
         rd0_addr  <= '0;
      end else if (state == S_INIT) begin
         init_busy <= 1'b1;
         wr0_en    <= 1'b1;
         wr0_addr  <= init_cnt;
         wr0_data  <= '0;
         wr1_en    <= 1'b0;
         rd0_en    <= 1'b0;
         init_cnt  <= init_cnt + ADDR_W'(1);
         if (init_cnt == '1) begin
            state <= S_RUN;
         end
      end else begin
         init_busy <= 1'b0;
         wr0_en    <= w0_found;
         wr0_addr  <= w0_addr;
         wr0_data  <= wdata_arr[w0_idx];
         wr1_en    <= w1_found;
         wr1_addr  <= w1_addr;
         wr1_data  <= wdata_arr[w1_idx];
         rd0_en    <= r_found;
         rd0_addr  <= addr_arr[r_idx];
         rd_id     <= r_idx;
         if (w1_found) begin
            wptr <= next_id(w1_idx);
         end else if (w0_found) begin
            wptr <= next_id(w0_idx);
         end
         if (r_found) begin
            rptr <= next_id(r_idx);
         end
      end
   end

   // Carry {valid, id} of each issued read alongside the memory read latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_valid <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_id[i] <= '0;
         end
      end else begin
         pipe_valid[0] <= rd0_en;
         pipe_id[0]    <= rd_id;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_id[i]    <= pipe_id[i-1];
         end
      end
   end

   assign rsp_valid = pipe_valid[RD_LAT-1];
   assign rsp_id    = pipe_id[RD_LAT-1];
   assign rsp_data  = rsp_valid ? rd0_data : '0;

endmodule

// File: tb/tb_lvt_mem_scheduler.sv
// tb_lvt_mem_scheduler: directed bench for lvt_mem_scheduler with a simple
// 2W/1R memory model attached to the issue ports.
module tb_lvt_mem_scheduler;

   localparam int NREQ   = 4;
   localparam int ADDR_W = 7;
   localparam int DATA_W = 32;
   localparam int RD_LAT = 1;
   localparam int NVEC   = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    req_valid;
   logic [3:0]    req_we;
   logic [27:0]   req_addr;
   logic [127:0]  req_wdata;
   logic [3:0]    req_ready;
   logic          rsp_valid;
   logic [1:0]    rsp_id;
   logic [31:0]   rsp_data;
   logic          wr0_en;
   logic [6:0]    wr0_addr;
   logic [31:0]   wr0_data;
   logic          wr1_en;
   logic [6:0]    wr1_addr;
   logic [31:0]   wr1_data;
   logic          rd0_en;
   logic [6:0]    rd0_addr;
   logic [31:0]   rd0_data = '0;
   logic          init_busy;

   logic [31:0]   mem [128] = '{default: 32'h0};

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int valid, we;
      int a0, a1, a2, a3;
      int d0, d1, d2, d3;
      int rdy;
      int w0e, w0a, w0d;
      int w1e, w1a, w1d;
      int r0e, r0a;
      int rv, rid, rd;
   } vec_t;

   vec_t vecs [NVEC];

   lvt_mem_scheduler #(
      .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .INIT_EN(1)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data),
      .init_busy(init_busy)
   );

   always #5 clk = ~clk;

   // Memory: writes land at the edge after issue, reads return one cycle after issue
   always @(posedge clk) begin
      if (wr0_en) mem[wr0_addr] <= wr0_data;
      if (wr1_en) mem[wr1_addr] <= wr1_data;
      if (rd0_en) rd0_data <= mem[rd0_addr];
   end

   task automatic check_output(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic apply_stimulus(input vec_t v);
      req_valid = 4'(v.valid);
      req_we    = 4'(v.we);
      req_addr  = {7'(v.a3), 7'(v.a2), 7'(v.a1), 7'(v.a0)};
      req_wdata = {32'(v.d3), 32'(v.d2), 32'(v.d1), 32'(v.d0)};
   endtask

   task automatic drive_idle();
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      //           valid   we      a0 a1 a2 a3  d0    d1    d2    d3  rdy     w0e w0a w0d    w1e w1a w1d    r0e r0a  rv rid rd
      vecs[0]  = '{'b0111, 'b0111, 10,11,12, 0, 'hA0, 'hA1, 'hA2, 0, 'b0011, 1, 10, 'hA0, 1, 11, 'hA1, 0, 0,  0, 0, 0};
      vecs[1]  = '{'b0111, 'b0111, 13,14,12, 0, 'hA3, 'hA4, 'hA2, 0, 'b0101, 1, 12, 'hA2, 1, 13, 'hA3, 0, 0,  0, 0, 0};
      vecs[2]  = '{'b0010, 'b0010,  0,14, 0, 0, 0,    'hA4, 0,    0, 'b0010, 1, 14, 'hA4, 0, 0,  0,    0, 0,  0, 0, 0};
      vecs[3]  = '{'b0011, 'b0011,  5, 9, 0, 0, 'h11, 'h22, 0,    0, 'b0011, 1, 5,  'h11, 1, 9,  'h22, 0, 0,  0, 0, 0};
      vecs[4]  = '{'b0011, 'b0011,  7, 7, 0, 0, 1,    2,    0,    0, 'b0001, 1, 7,  1,    0, 0,  0,    0, 0,  0, 0, 0};
      vecs[5]  = '{'b0010, 'b0010,  0, 7, 0, 0, 0,    2,    0,    0, 'b0010, 1, 7,  2,    0, 0,  0,    0, 0,  0, 0, 0};
      vecs[6]  = '{'b1000, 'b0000,  0, 0, 0, 7, 0,    0,    0,    0, 'b1000, 0, 0,  0,    0, 0,  0,    1, 7,  0, 0, 0};
      vecs[7]  = '{'b1100, 'b0100,  0, 0, 3, 3, 0,    0,    'hAB, 0, 'b0100, 1, 3,  'hAB, 0, 0,  0,    0, 0,  1, 3, 2};
      vecs[8]  = '{'b1000, 'b0000,  0, 0, 0, 3, 0,    0,    0,    0, 'b1000, 0, 0,  0,    0, 0,  0,    1, 3,  0, 0, 0};
      vecs[9]  = '{'b0000, 'b0000,  0, 0, 0, 0, 0,    0,    0,    0, 'b0000, 0, 0,  0,    0, 0,  0,    0, 0,  1, 3, 'hAB};
      vecs[10] = '{'b1111, 'b0110,  5,20,21, 9, 0,    'h55, 'h66, 0, 'b0111, 1, 20, 'h55, 1, 21, 'h66, 1, 5,  0, 0, 0};
      vecs[11] = '{'b1000, 'b0000,  0, 0, 0, 9, 0,    0,    0,    0, 'b1000, 0, 0,  0,    0, 0,  0,    1, 9,  1, 0, 'h11};
      vecs[12] = '{'b0000, 'b0000,  0, 0, 0, 0, 0,    0,    0,    0, 'b0000, 0, 0,  0,    0, 0,  0,    0, 0,  1, 3, 'h22};
      vecs[13] = '{'b0111, 'b0011, 30,31,31, 0, 1,    2,    0,    0, 'b0011, 1, 30, 1,    1, 31, 2,    0, 0,  0, 0, 0};
      vecs[14] = '{'b0100, 'b0000,  0, 0,31, 0, 0,    0,    0,    0, 'b0100, 0, 0,  0,    0, 0,  0,    1, 31, 0, 0, 0};
      vecs[15] = '{'b0000, 'b0000,  0, 0, 0, 0, 0,    0,    0,    0, 'b0000, 0, 0,  0,    0, 0,  0,    0, 0,  1, 2, 2};

      // Reset with requests pending: everything must stay quiet
      req_valid = '1;
      req_we    = 4'b0101;
      req_addr  = {7'd3, 7'd2, 7'd1, 7'd0};
      req_wdata = '1;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset req_ready", 32'(req_ready), 0);
      check_output("reset init_busy", 32'(init_busy), 0);
      check_output("reset wr0_en", 32'(wr0_en), 0);
      check_output("reset wr1_en", 32'(wr1_en), 0);
      check_output("reset rd0_en", 32'(rd0_en), 0);
      check_output("reset rsp_valid", 32'(rsp_valid), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_output("pre-sweep init_busy", 32'(init_busy), 0);

      // Clear sweep: 128 cycles of wr0 with addresses 0..127, no grants even with requests held
      for (int k = 0; k < 128; k++) begin
         @(posedge clk);
         #1;
         check_output($sformatf("sweep%0d init_busy", k), 32'(init_busy), 1);
         check_output($sformatf("sweep%0d wr0_en", k), 32'(wr0_en), 1);
         check_output($sformatf("sweep%0d wr0_addr", k), 32'(wr0_addr), k);
         check_output($sformatf("sweep%0d wr0_data", k), wr0_data, 0);
         check_output($sformatf("sweep%0d wr1_en", k), 32'(wr1_en), 0);
         check_output($sformatf("sweep%0d rd0_en", k), 32'(rd0_en), 0);
         check_output($sformatf("sweep%0d req_ready", k), 32'(req_ready), 0);
      end
      drive_idle();
      @(posedge clk);
      #1;
      check_output("post-sweep init_busy", 32'(init_busy), 0);
      check_output("post-sweep wr0_en", 32'(wr0_en), 0);

      // Table-driven arbitration, issue and response vectors
      for (int i = 0; i < NVEC; i++) begin
         apply_stimulus(vecs[i]);
         #1;
         check_output($sformatf("v%0d req_ready", i), 32'(req_ready), vecs[i].rdy);
         @(posedge clk);
         #1;
         check_output($sformatf("v%0d wr0_en", i), 32'(wr0_en), vecs[i].w0e);
         if (vecs[i].w0e != 0) begin
            check_output($sformatf("v%0d wr0_addr", i), 32'(wr0_addr), vecs[i].w0a);
            check_output($sformatf("v%0d wr0_data", i), wr0_data, vecs[i].w0d);
         end
         check_output($sformatf("v%0d wr1_en", i), 32'(wr1_en), vecs[i].w1e);
         if (vecs[i].w1e != 0) begin
            check_output($sformatf("v%0d wr1_addr", i), 32'(wr1_addr), vecs[i].w1a);
            check_output($sformatf("v%0d wr1_data", i), wr1_data, vecs[i].w1d);
         end
         check_output($sformatf("v%0d rd0_en", i), 32'(rd0_en), vecs[i].r0e);
         if (vecs[i].r0e != 0) begin
            check_output($sformatf("v%0d rd0_addr", i), 32'(rd0_addr), vecs[i].r0a);
         end
         check_output($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), vecs[i].rv);
         if (vecs[i].rv != 0) begin
            check_output($sformatf("v%0d rsp_id", i), 32'(rsp_id), vecs[i].rid);
            check_output($sformatf("v%0d rsp_data", i), rsp_data, vecs[i].rd);
         end
      end

      // Read in flight when reset hits: response is dropped and the sweep restarts at 0
      req_valid = 4'b0010;
      req_we    = 4'b0000;
      req_addr  = {7'd0, 7'd0, 7'd9, 7'd0};
      req_wdata = '0;
      #1;
      check_output("rstmid req_ready", 32'(req_ready), 32'b0010);
      @(posedge clk);
      #1;
      check_output("rstmid rd0_en", 32'(rd0_en), 1);
      check_output("rstmid rd0_addr", 32'(rd0_addr), 9);
      drive_idle();
      rst = 1'b1;
      #1;
      check_output("rstmid async rd0_en", 32'(rd0_en), 0);
      check_output("rstmid async init_busy", 32'(init_busy), 0);
      check_output("rstmid async rsp_valid", 32'(rsp_valid), 0);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         check_output($sformatf("rstmid hold%0d rsp_valid", k), 32'(rsp_valid), 0);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         check_output($sformatf("resweep%0d init_busy", k), 32'(init_busy), 1);
         check_output($sformatf("resweep%0d wr0_en", k), 32'(wr0_en), 1);
         check_output($sformatf("resweep%0d wr0_addr", k), 32'(wr0_addr), k);
         check_output($sformatf("resweep%0d rsp_valid", k), 32'(rsp_valid), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
